// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared op encoding, control states and FIFO sizing helper for sram_1rw_ctrl
package sram_ctrl_pkg;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } ctrl_state_e;

    // Count must represent 0..depth inclusive, hence one bit above the pointer width.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sram_ctrl_rsp_fifo.sv
// rtl/sram_ctrl_rsp_fifo.sv - synchronous response FIFO with push/pop/count for sram_1rw_ctrl
module sram_ctrl_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int RSP_DEPTH  = 4,
    localparam int CW = fifo_cnt_w(RSP_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_pop_data,
    output logic [CW-1:0]         o_count,
    output logic                  o_empty
);

    localparam int PW = $clog2(RSP_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_pop;

    assign w_pop      = i_pop && (r_count != '0);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    // The credit check upstream must make a push into a full FIFO impossible.
    always @(posedge i_clk) begin
        if (!i_rst && i_push && !w_pop) assert (r_count != CW'(RSP_DEPTH));
    end

endmodule

// File: rtl/sram_1rw_ctrl.sv
// rtl/sram_1rw_ctrl.sv - request/response controller for a 1RW OpenRAM macro; SRAM_1RW_CTRL_INIT_EN adds zero-fill after reset
module sram_1rw_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  busy
);

    localparam int CW = fifo_cnt_w(RSP_DEPTH);
    localparam int UW = CW + 1;

    logic                  r_csb;
    logic                  r_web;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_rd_p1;
    logic                  r_rd_p2;
    logic [CW-1:0]         w_count;
    logic                  w_empty;
    logic [UW-1:0]         w_used;
    logic                  w_accept;
    logic                  w_run;
    logic                  w_init_issue;
    logic [ADDR_WIDTH-1:0] w_init_addr;

`ifdef SRAM_1RW_CTRL_INIT_EN
    ctrl_state_e           r_state;
    logic [ADDR_WIDTH-1:0] r_init_addr;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_state     <= IDLE;
            r_init_addr <= '0;
        end else begin
            case (r_state)
                IDLE: r_state <= INIT;
                INIT: begin
                    r_init_addr <= r_init_addr + ADDR_WIDTH'(1);
                    if (r_init_addr == {ADDR_WIDTH{1'b1}}) r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign w_init_issue = (r_state == INIT);
    assign w_init_addr  = r_init_addr;
    assign w_run        = (r_state == RUN);
    assign busy         = w_init_issue;
`else
    assign w_init_issue = 1'b0;
    assign w_init_addr  = '0;
    assign w_run        = 1'b1;
    assign busy         = 1'b0;
`endif

    // Reads in the macro pipeline already own a FIFO slot, so writes are throttled by the same credit.
    assign w_used    = UW'(r_rd_p1) + UW'(r_rd_p2) + UW'(w_count);
    assign req_ready = w_run && !busy && (w_used < UW'(RSP_DEPTH));
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = !w_empty;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_addr  <= '0;
            r_din   <= '0;
            r_rd_p1 <= 1'b0;
            r_rd_p2 <= 1'b0;
        end else begin
            r_rd_p2 <= r_rd_p1;
            r_rd_p1 <= w_accept && (req_we == OP_RD);
            if (w_init_issue) begin
                r_csb  <= 1'b0;
                r_web  <= 1'b0;
                r_addr <= w_init_addr;
                r_din  <= '0;
            end else if (w_accept) begin
                r_csb  <= 1'b0;
                r_web  <= (req_we != OP_WR);
                r_addr <= req_addr;
                r_din  <= req_wdata;
            end else begin
                r_csb <= 1'b1;
                r_web <= 1'b1;
            end
        end
    end

    assign csb0  = r_csb;
    assign web0  = r_web;
    assign addr0 = r_addr;
    assign din0  = r_din;

    // dout0 settles after the macro's negedge, so the rd_p2 edge is the first safe capture point.
    sram_ctrl_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .i_clk       (clk0),
        .i_rst       (rst0),
        .i_push      (r_rd_p2),
        .i_push_data (dout0),
        .i_pop       (rsp_ready),
        .o_pop_data  (rsp_rdata),
        .o_count     (w_count),
        .o_empty     (w_empty)
    );

endmodule

// File: doc/sram_1rw_ctrl.md
Name: sram_1rw_ctrl

Overview:
- Initiator-side controller for a single-port 1RW OpenRAM macro with ports clk0, csb0, web0, addr0, din0 and dout0.
- Converts a valid/ready request stream (read or write) into macro port cycles.
- Captures read data at the correct edge and returns it on a valid/ready response stream, with a response FIFO to absorb backpressure.
- Sits between a bus/DMA client and the generated SRAM instance.

Parameters:
- DATA_WIDTH, 2, macro word width.
- ADDR_WIDTH, 4, macro address width; depth = 1<<ADDR_WIDTH.
- RSP_DEPTH, 4, response FIFO entries (power of two, >=2).

Ports:
- clk0 in 1: single clock, shared with the macro.
- rst0 in 1: synchronous, active-high reset.
- req_valid in 1: request present.
- req_ready out 1: controller accepts the request this cycle.
- req_we in 1: 1 = write, 0 = read.
- req_addr in ADDR_WIDTH: word address.
- req_wdata in DATA_WIDTH: write data.
- rsp_valid out 1: read data available.
- rsp_ready in 1: consumer takes the read data.
- rsp_rdata out DATA_WIDTH: read data.
- csb0 out 1: to macro; active-low chip select.
- web0 out 1: to macro; active-low write enable.
- addr0 out ADDR_WIDTH: to macro.
- din0 out DATA_WIDTH: to macro.
- dout0 in DATA_WIDTH: from macro.
- busy out 1: init sequence running (always 0 without the optional feature).

Behaviour:
- Reset values: csb0=1, web0=1, addr0=0, din0=0, rsp_valid=0, rsp_rdata=0, busy=0. On reset the FIFO is emptied, in-flight counter cleared and pipeline valids cleared.
- Reset is synchronous and active-high; it may assert mid-operation and discards all in-flight reads.
- Accept = req_valid && req_ready, sampled at posedge N. At N, registered outputs load: csb0=0, web0=!req_we, addr0, din0. If nothing is accepted at N, csb0=1 and web0=1; addr0 and din0 hold.
- All macro-port outputs are driven from posedge flops only; no combinational path from req_* to macro pins.
- Read pipeline:
  - The macro samples at N+1 and dout0 becomes valid after the N+1 negedge.
  - The controller samples dout0 at posedge N+2 and pushes it into the FIFO.
  - rsp_valid is visible in the cycle after N+2, i.e. read latency is 2 cycles from accept to FIFO write and 3 cycles to rsp_valid.
  - A 2-stage read-tag shift register (rd_p1, rd_p2) tracks which cycles carry reads.
- Writes produce no response. Writes complete at the N+1 negedge inside the macro.
- Back-to-back operation: one request per cycle sustained when the FIFO is not full and rsp_ready=1.
- Ordering: a read issued the cycle after a write to the same address returns the new data, since the macro writes at the negedge before the read sample.
- Credit rule: req_ready = !busy && (inflight + fifo_count < RSP_DEPTH).
  - inflight (0..2) counts reads in rd_p1/rd_p2.
  - The rule is applied to all requests, reads and writes alike.
- FIFO: push at N+2 and pop on rsp_valid && rsp_ready in the same cycle are both allowed; count is unchanged.
  - Full never occurs at push, guaranteed by the credit rule; an overflow attempt is an assertion failure.
  - Empty implies rsp_valid=0.
  - Pointers wrap modulo RSP_DEPTH.
  - rsp_rdata holds stable while rsp_valid && !rsp_ready.
- Addresses wrap naturally at ADDR_WIDTH. No X is ever driven to the macro after reset.

Optional Feature:
- Macro: SRAM_1RW_CTRL_INIT_EN.
- Defined: after reset release, an FSM runs IDLE -> INIT -> RUN.
  - INIT writes 0 to addresses 0..depth-1, one per cycle, with csb0=0, web0=0, din0=0.
  - busy=1 and req_ready=0 during INIT.
  - After the last address (depth-1) is issued, the FSM enters RUN on the next edge; busy falls once RUN is entered.
  - Reset during INIT restarts at address 0.
- Undefined: the FSM is absent, the controller enters RUN directly, and busy is tied to 0.

Decomposition:
- Package sram_ctrl_pkg holds:
  - the op encoding constants (OP_RD=0, OP_WR=1),
  - the ctrl state enum (IDLE, INIT, RUN),
  - a function computing the FIFO count width from RSP_DEPTH.
- One sub-module: sram_ctrl_rsp_fifo, a synchronous FIFO with push/pop/count and DATA_WIDTH, RSP_DEPTH parameters.
- Simulate against the behavioural macro model.

Test Plan:
- Reset, then single write addr=3 data=2'b10, then read addr=3: csb0/web0 pulse correctly, rsp_valid 3 cycles after the read accept, rsp_rdata=2'b10.
- Write all 16 addresses with data=addr[1:0], then 16 back-to-back reads with rsp_ready=1: 16 consecutive rsp_valid cycles, data in order, req_ready never drops.
- rsp_ready=0 with continuous reads: exactly RSP_DEPTH reads accepted, then req_ready=0. Release rsp_ready: all data returned in order, no loss or duplication.
- Write addr=5 then read addr=5 on the next cycle: read returns the new data.
- Assert rst0 with 2 reads in flight and the FIFO at 2 entries: next cycle rsp_valid=0, csb0=1, req_ready=1, and no stale responses appear later.
- With SRAM_1RW_CTRL_INIT_EN: busy=1 for 16 cycles after reset, all macro words read 0; without the macro, busy=0 and req_ready=1 the first cycle after reset.
